// File: rtl/srlfifo32x8_if.sv
`default_nettype none
// ============================================================================
//  Module   : srlfifo32x8_if
//  Purpose  : Bundles the data/handshake/status signals of the srlfifo32x8
//             show-ahead FIFO.
//  Ports    : master - drives d, wr, rd, clr; observes y and status
//             slave  - the FIFO side (mirror of master)
//  Signals  : d/y (W bits) write/read data, wr/rd requests, clr sync clear,
//             empty/full/afull/cnt occupancy status, ovf/unf sticky errors
//  Revision : 1.0 - initial release
// ============================================================================
interface srlfifo32x8_if #(
  parameter int W = 8
);
  logic [W-1:0] d;
  logic         wr;
  logic         rd;
  logic         clr;
  logic [W-1:0] y;
  logic         empty;
  logic         full;
  logic         afull;
  logic [5:0]   cnt;
  logic         ovf;
  logic         unf;

  modport master (
    output d, wr, rd, clr,
    input  y, empty, full, afull, cnt, ovf, unf
  );

  modport slave (
    input  d, wr, rd, clr,
    output y, empty, full, afull, cnt, ovf, unf
  );
endinterface
`default_nettype wire

// File: rtl/srlfifo32x8.sv
`default_nettype none
// ============================================================================
//  Module   : srlfifo32x8
//  Purpose  : 32-word show-ahead FIFO built on an addressable shift register.
//             Writes shift into stage 0; the occupancy counter selects the
//             tap so the oldest word is always presented on y.
//  Ports    : clk   - clock, rising edge
//             rstn  - asynchronous active-low reset (occupancy and flags only)
//             bus   - srlfifo32x8_if.slave: d, wr, rd, clr in;
//                     y, empty, full, afull, cnt, ovf, unf out
//  Revision : 1.0 - initial release
// ============================================================================
module srlfifo32x8 #(
  parameter int W     = 8,
  parameter int AFULL = 24
) (
  input  wire logic          clk,
  input  wire logic          rstn,
  srlfifo32x8_if.slave       bus
);

  localparam int          DEPTH   = 32;
  localparam logic [5:0]  C_FULL  = 6'(DEPTH);
  localparam logic [5:0]  C_AFULL = 6'(AFULL);

  // Storage has no reset: stale contents are hidden behind empty/cnt.
  logic [W-1:0] srl_q [DEPTH];

  logic [5:0] cnt_q, cnt_d;
  logic       ovf_q, ovf_d;
  logic       unf_q, unf_d;

  logic       w_empty, w_full;
  logic       w_we, w_re;
  logic [4:0] w_tap;

  // Status is a pure decode of the registered count; no wr/rd feedthrough.
  assign w_empty = (cnt_q == 6'd0);
  assign w_full  = (cnt_q == C_FULL);

  // A write is allowed at full only if a pop frees the slot in the same edge.
  // clr suppresses both so that nothing shifts during a clear.
  assign w_we = bus.wr & (~w_full | bus.rd) & ~bus.clr;
  assign w_re = bus.rd & ~w_empty & ~bus.clr;

  // Tap = cnt-1; at cnt=32 the 5-bit subtraction lands on 31 as required.
  assign w_tap = w_empty ? 5'd0 : (cnt_q[4:0] - 5'd1);

  always_ff @(posedge clk) begin
    if (w_we) begin
      srl_q[0] <= bus.d;
      for (int i = 1; i < DEPTH; i++) begin
        srl_q[i] <= srl_q[i-1];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (bus.clr) begin
      cnt_d = 6'd0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      cnt_d = cnt_q + {5'd0, w_we} - {5'd0, w_re};
      // Error conditions look at the raw requests, not the accepted ones.
      if (bus.wr & w_full & ~bus.rd) ovf_d = 1'b1;
      if (bus.rd & w_empty)          unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= 6'd0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.y     = srl_q[w_tap];
  assign bus.empty = w_empty;
  assign bus.full  = w_full;
  assign bus.afull = (cnt_q >= C_AFULL);
  assign bus.cnt   = cnt_q;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_srlfifo32x8.sv
`default_nettype none
// ============================================================================
//  Module   : tb_srlfifo32x8
//  Purpose  : Self-checking bench for srlfifo32x8: a directed vector table,
//             hand-written fill/drain/overflow/clear sequences and a random
//             streaming run against a queue model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_srlfifo32x8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  srlfifo32x8_if #(.W(8)) bus ();

  srlfifo32x8 #(.W(8), .AFULL(24)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       wr, rd, clr;
    logic [7:0] d;
    logic [5:0] exp_cnt;
    logic       exp_empty, exp_full, exp_ovf, exp_unf;
    logic       chk_y;
    logic [7:0] exp_y;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic r, input logic c, input logic [7:0] dd);
    bus.wr  = w;
    bus.rd  = r;
    bus.clr = c;
    bus.d   = dd;
  endtask

  // Outputs are sampled and inputs changed 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill();
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b0, 1'b0, 8'(i));
      tick();
      chk("fill_cnt",   bus.cnt,   32'(i + 1));
      chk("fill_y",     bus.y,     32'h00);
      chk("fill_afull", bus.afull, 32'((i + 1) >= 24));
      chk("fill_full",  bus.full,  32'((i + 1) == 32));
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // Pops 32 words; a5_tail selects the sequence after the push+pop at full.
  task automatic drain(input bit a5_tail);
    logic [7:0] exp;
    for (int i = 0; i < 32; i++) begin
      if (a5_tail) exp = (i == 31) ? 8'hA5 : 8'(i + 1);
      else         exp = 8'(i);
      chk("drain_y", bus.y, 32'(exp));
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    chk("drain_empty", bus.empty, 32'h1);
    chk("drain_cnt",   bus.cnt,   32'h0);
    chk("drain_unf",   bus.unf,   32'h0);
  endtask

  logic [7:0] q [$];

  initial begin
    drive(1'b0, 1'b0, 1'b0, 8'h00);

    // ---------------- reset state ----------------
    #12;
    chk("rst_cnt",   bus.cnt,   32'h0);
    chk("rst_empty", bus.empty, 32'h1);
    chk("rst_full",  bus.full,  32'h0);
    chk("rst_afull", bus.afull, 32'h0);
    chk("rst_ovf",   bus.ovf,   32'h0);
    chk("rst_unf",   bus.unf,   32'h0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // ---------------- vector table ----------------
    //           wr  rd  clr  d      cnt emp ful ovf unf chky y
    tbl[0] = '{1'b1, 1'b1, 1'b0, 8'h3C, 6'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 8'h11, 6'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 8'h00, 6'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 8'h22, 6'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h22};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 8'h00, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 8'h99, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 8'h00, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    for (int v = 0; v < 7; v++) begin
      drive(tbl[v].wr, tbl[v].rd, tbl[v].clr, tbl[v].d);
      tick();
      chk($sformatf("vec%0d_cnt", v),   bus.cnt,   32'(tbl[v].exp_cnt));
      chk($sformatf("vec%0d_empty", v), bus.empty, 32'(tbl[v].exp_empty));
      chk($sformatf("vec%0d_full", v),  bus.full,  32'(tbl[v].exp_full));
      chk($sformatf("vec%0d_ovf", v),   bus.ovf,   32'(tbl[v].exp_ovf));
      chk($sformatf("vec%0d_unf", v),   bus.unf,   32'(tbl[v].exp_unf));
      if (tbl[v].chk_y) chk($sformatf("vec%0d_y", v), bus.y, 32'(tbl[v].exp_y));
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);

    // ---------------- mid-stream asynchronous reset ----------------
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 8'hE0 + 8'(i));
      tick();
    end
    chk("pre_rst_cnt", bus.cnt, 32'h3);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_cnt",   bus.cnt,   32'h0);
    chk("async_rst_empty", bus.empty, 32'h1);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    rstn = 1'b1;
    tick();
    chk("post_rst_cnt", bus.cnt, 32'h0);

    // ---------------- fill and drain order ----------------
    fill();
    chk("full_cnt", bus.cnt, 32'd32);
    drain(1'b0);

    // ---------------- push+pop at full ----------------
    fill();
    drive(1'b1, 1'b1, 1'b0, 8'hA5);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    chk("simfull_cnt", bus.cnt, 32'd32);
    chk("simfull_ovf", bus.ovf, 32'h0);
    chk("simfull_y",   bus.y,   32'h01);
    drain(1'b1);

    // ---------------- overflow then clear ----------------
    fill();
    drive(1'b1, 1'b0, 1'b0, 8'h77);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    chk("ovf_flag", bus.ovf, 32'h1);
    chk("ovf_cnt",  bus.cnt, 32'd32);
    drain(1'b0);
    chk("ovf_sticky", bus.ovf, 32'h1);
    drive(1'b1, 1'b0, 1'b1, 8'h55);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    chk("clr_cnt",   bus.cnt,   32'h0);
    chk("clr_ovf",   bus.ovf,   32'h0);
    chk("clr_unf",   bus.unf,   32'h0);
    chk("clr_empty", bus.empty, 32'h1);

    // ---------------- random streaming vs queue model ----------------
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      int         pw;
      logic       w, r, we, re;
      logic [7:0] dd;
      pw = ((c / 500) % 2 == 0) ? 70 : 30;
      w  = ($urandom_range(99) < pw);
      r  = ($urandom_range(99) < (100 - pw));
      dd = 8'($urandom_range(255));
      re = r && (q.size() > 0);
      we = w && ((q.size() < 32) || r);
      if (re) chk("stream_y", bus.y, 32'(q[0]));
      drive(w, r, 1'b0, dd);
      tick();
      if (re) void'(q.pop_front());
      if (we) q.push_back(dd);
      chk("stream_cnt", bus.cnt, 32'(q.size()));
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
